bird_vertical_ctrl: RTL and testbench
=====================================

Name: bird_vertical_ctrl

Overview:
- Vertical-motion stage for Flappy Bird.
- Sits directly downstream of the fall-rate tick counter. It consumes that counter's one-cycle fall tick, the player's flap key and the pipe-collision flag.
- It maintains the bird's row on the LED matrix and the game-phase state.
- Feeds the display driver (one-hot row) and the game-over logic.

Parameters:
- ROWS, 16, number of matrix rows; row 0 is the top, ROWS-1 is the ground.
- ROW_W, 4, width of bird_row; must satisfy 2^ROW_W >= ROWS.
- START_ROW, 7, bird row after reset and after restart.
- FLAP_HEIGHT, 3, rows climbed per flap, one per fall tick; must be >= 1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- fall_tick  in  1  one-cycle pulse from the fall-rate counter
- flap_key  in  1  synchronized, debounced flap key level; 1 = pressed
- hit  in  1  pipe-collision flag, level, sampled each cycle
- bird_row  out  ROW_W  current bird row
- bird_onehot  out  ROWS  one-hot of bird_row, bit i = row i
- playing  out  1  1 in RISE or FALL
- crashed  out  1  1 in DEAD

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, bird_row=START_ROW, rise_cnt=0, key_q=0.
  - playing=0, crashed=0.
  - bird_onehot has only bit START_ROW set.
- Edge detection:
  - key_q registers flap_key every cycle.
  - flap_pulse = flap_key & ~key_q (combinational).
  - A held key yields exactly one pulse.
- All state, row and rise_cnt updates take effect on the posedge where the triggering input is high. Outputs are registered, or decoded from registers only, so latency is 1 cycle.
- Priority each cycle: hit > flap_pulse > fall_tick.
- IDLE:
  - flap_pulse -> RISE, rise_cnt=FLAP_HEIGHT, row unchanged.
  - fall_tick and hit are ignored.
- RISE:
  - hit -> DEAD, row frozen.
  - flap_pulse -> rise_cnt reloads to FLAP_HEIGHT; stays RISE; row unchanged that cycle, even if fall_tick is also high.
  - fall_tick (no flap) -> row = row-1, saturating at 0, and rise_cnt = rise_cnt-1. If the new rise_cnt is 0 -> FALL.
- FALL:
  - hit -> DEAD.
  - flap_pulse -> RISE, rise_cnt=FLAP_HEIGHT.
  - fall_tick -> row = row+1. If the new row == ROWS-1 -> DEAD on the same edge (ground crash).
- DEAD:
  - row frozen; ticks and hit are ignored.
  - flap_pulse -> IDLE, row=START_ROW, rise_cnt=0.
- Arithmetic:
  - Row math is unsigned ROW_W bits.
  - Decrement at row 0 holds 0, but rise_cnt still decrements.
  - Increment never exceeds ROWS-1, because reaching ROWS-1 forces DEAD.
- Outputs:
  - playing = (state==RISE)|(state==FALL).
  - crashed = (state==DEAD).
  - bird_onehot is always exactly one-hot.
- Reset asserted mid-game (any state) forces the reset values immediately, without waiting for clk.
- No illegal state persists: unused encodings go to IDLE on the next clk.

Test Plan (ROWS=8, ROW_W=3, START_ROW=3, FLAP_HEIGHT=2):
1. Reset low then high, 5 fall_ticks, no flap -> bird_row=3, state IDLE, bird_onehot=8'b0000_1000, playing=0, crashed=0.
2. Flap key held 10 cycles, then 2 ticks, then 1 tick -> exactly one RISE entry; row 3->2->1 with FALL entered on the 2nd tick; 3rd tick row=2, playing=1.
3. From FALL at row 5, 2 ticks -> row 6, then row 7 with crashed=1 on the same edge; further ticks keep row=7; a flap pulse -> IDLE, row=3, crashed=0.
4. RISE at row 0 with rise_cnt=2, 2 ticks -> row stays 0, FALL after the 2nd tick; the next tick gives row=1.
5. Same cycle hit=1, flap_pulse=1, fall_tick=1 while in FALL at row 4 -> DEAD, row=4. Same cycle flap_pulse=1 and fall_tick=1 in FALL at row 4 -> RISE, row=4, rise_cnt=2.
6. Reset driven low asynchronously mid-clock while in RISE at row 1 -> immediately row=3, IDLE, playing=0, before the next posedge.

Source files
------------

// File: rtl/bird_vertical_ctrl.sv
// Bird vertical-motion stage: tracks the bird row on the LED matrix and the
// game phase (IDLE / RISE / FALL / DEAD) from fall ticks, flap key and hits.
module bird_vertical_ctrl #(
    parameter int unsigned ROWS        = 16,
    parameter int unsigned ROW_W       = 4,
    parameter int unsigned START_ROW   = 7,
    parameter int unsigned FLAP_HEIGHT = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fall_tick,
    input  logic             flap_key,
    input  logic             hit,
    output logic [ROW_W-1:0] bird_row,
    output logic [ROWS-1:0]  bird_onehot,
    output logic             playing,
    output logic             crashed
);

    localparam int unsigned     CNT_W    = $clog2(FLAP_HEIGHT + 1);
    localparam logic [ROW_W-1:0] START_R = ROW_W'(START_ROW);
    localparam logic [ROW_W-1:0] GROUND  = ROW_W'(ROWS - 1);
    localparam logic [CNT_W-1:0] FLAP_CNT = CNT_W'(FLAP_HEIGHT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RISE = 2'd1,
        S_FALL = 2'd2,
        S_DEAD = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [CNT_W-1:0] rise_cnt_q, rise_cnt_d;
    logic             key_q;
    logic [ROWS-1:0]  onehot_q, onehot_d;
    logic             playing_q, playing_d;
    logic             crashed_q, crashed_d;
    logic             flap_pulse;

    // Rising edge of the flap key: a held key gives a single pulse
    always_comb begin
        flap_pulse = flap_key & ~key_q;
    end

    // Next-state, row and climb-counter logic; priority hit > flap > tick
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        rise_cnt_d = rise_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (flap_pulse) begin
                    state_d    = S_RISE;
                    rise_cnt_d = FLAP_CNT;
                end
            end
            S_RISE: begin
                if (hit) begin
                    state_d = S_DEAD;
                end else if (flap_pulse) begin
                    rise_cnt_d = FLAP_CNT;
                end else if (fall_tick) begin
                    if (row_q != '0) begin
                        row_d = row_q - ROW_W'(1);
                    end
                    if (rise_cnt_q <= CNT_W'(1)) begin
                        rise_cnt_d = '0;
                        state_d    = S_FALL;
                    end else begin
                        rise_cnt_d = rise_cnt_q - CNT_W'(1);
                    end
                end
            end
            S_FALL: begin
                if (hit) begin
                    state_d = S_DEAD;
                end else if (flap_pulse) begin
                    state_d    = S_RISE;
                    rise_cnt_d = FLAP_CNT;
                end else if (fall_tick) begin
                    // Reaching the ground row is a crash on the same edge
                    if (row_q >= GROUND - ROW_W'(1)) begin
                        row_d   = GROUND;
                        state_d = S_DEAD;
                    end else begin
                        row_d = row_q + ROW_W'(1);
                    end
                end
            end
            S_DEAD: begin
                if (flap_pulse) begin
                    state_d    = S_IDLE;
                    row_d      = START_R;
                    rise_cnt_d = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output values precomputed from next state so outputs come straight off flops
    always_comb begin
        playing_d = (state_d == S_RISE) | (state_d == S_FALL);
        crashed_d = (state_d == S_DEAD);
        onehot_d  = ROWS'(1) << row_d;
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            row_q      <= START_R;
            rise_cnt_q <= '0;
            key_q      <= 1'b0;
            onehot_q   <= ROWS'(1) << START_R;
            playing_q  <= 1'b0;
            crashed_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            rise_cnt_q <= rise_cnt_d;
            key_q      <= flap_key;
            onehot_q   <= onehot_d;
            playing_q  <= playing_d;
            crashed_q  <= crashed_d;
        end
    end

    assign bird_row    = row_q;
    assign bird_onehot = onehot_q;
    assign playing     = playing_q;
    assign crashed     = crashed_q;

endmodule

// File: tb/tb_bird_vertical_ctrl.sv
// Directed, table-driven bench for bird_vertical_ctrl (8-row configuration).
module tb_bird_vertical_ctrl;

    localparam int unsigned ROWS  = 8;
    localparam int unsigned ROW_W = 3;

    logic             clk;
    logic             reset;
    logic             fall_tick;
    logic             flap_key;
    logic             hit;
    logic [ROW_W-1:0] bird_row;
    logic [ROWS-1:0]  bird_onehot;
    logic             playing;
    logic             crashed;

    int errors;
    int checks;

    typedef struct {
        logic             f;
        logic             t;
        logic             h;
        logic [ROW_W-1:0] row;
        logic             play;
        logic             crash;
    } vec_t;

    vec_t vq[$];

    bird_vertical_ctrl #(
        .ROWS       (8),
        .ROW_W      (3),
        .START_ROW  (3),
        .FLAP_HEIGHT(2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .fall_tick  (fall_tick),
        .flap_key   (flap_key),
        .hit        (hit),
        .bird_row   (bird_row),
        .bird_onehot(bird_onehot),
        .playing    (playing),
        .crashed    (crashed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [ROW_W-1:0] erow,
                         input logic eplay, input logic ecrash);
        logic [ROWS-1:0] eoh;
        eoh = ROWS'(1) << erow;
        checks++;
        if (bird_row !== erow || bird_onehot !== eoh || playing !== eplay || crashed !== ecrash) begin
            errors++;
            $display("FAIL %s: got row=%0d oh=%b play=%b crash=%b, want row=%0d oh=%b play=%b crash=%b",
                     name, bird_row, bird_onehot, playing, crashed, erow, eoh, eplay, ecrash);
        end
    endtask

    // Drive on the falling edge, sample 1 time unit after the rising edge
    task automatic step(input logic f, input logic t, input logic h);
        @(negedge clk);
        flap_key  = f;
        fall_tick = t;
        hit       = h;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic f, input logic t, input logic h,
                       input int row, input logic play, input logic crash);
        vec_t v;
        v.f = f; v.t = t; v.h = h;
        v.row = ROW_W'(row);
        v.play = play; v.crash = crash;
        vq.push_back(v);
    endtask

    task automatic run_vecs(input string tag);
        int idx;
        idx = 0;
        while (vq.size() > 0) begin
            vec_t v;
            v = vq.pop_front();
            step(v.f, v.t, v.h);
            check($sformatf("%s[%0d]", tag, idx), v.row, v.play, v.crash);
            idx++;
        end
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        fall_tick = 1'b0;
        flap_key  = 1'b0;
        hit       = 1'b0;
        reset     = 1'b0;
        #12;
        check("reset", 3'd3, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        // Idle: ticks and hits are ignored
        for (int i = 0; i < 5; i++) add(0, 1, 0, 3, 0, 0);
        add(0, 1, 1, 3, 0, 0);
        run_vecs("idle");

        // Held key: a single RISE entry, later ticks are not blocked by repeat pulses
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 0);
            check($sformatf("hold[%0d]", i), 3'd3, 1'b1, 1'b0);
        end
        step(1, 1, 0); check("hold_tick1", 3'd2, 1'b1, 1'b0);
        step(1, 1, 0); check("hold_tick2", 3'd1, 1'b1, 1'b0);
        step(1, 1, 0); check("hold_tick3", 3'd2, 1'b1, 1'b0);

        // Fall to the ground, crash, restart
        add(0, 0, 0, 2, 1, 0);
        add(0, 1, 0, 3, 1, 0);
        add(0, 1, 0, 4, 1, 0);
        add(0, 1, 0, 5, 1, 0);
        add(0, 1, 0, 6, 1, 0);
        add(0, 1, 0, 7, 0, 1);
        add(0, 1, 0, 7, 0, 1);
        add(0, 0, 1, 7, 0, 1);
        add(1, 0, 0, 3, 0, 0);
        add(0, 0, 0, 3, 0, 0);
        // Climb to row 0 with counter reloads, then saturate at the top
        add(1, 0, 0, 3, 1, 0);
        add(0, 0, 0, 3, 1, 0);
        add(0, 1, 0, 2, 1, 0);
        add(1, 0, 0, 2, 1, 0);
        add(0, 0, 0, 2, 1, 0);
        add(0, 1, 0, 1, 1, 0);
        add(1, 0, 0, 1, 1, 0);
        add(0, 0, 0, 1, 1, 0);
        add(0, 1, 0, 0, 1, 0);
        add(1, 0, 0, 0, 1, 0);
        add(0, 0, 0, 0, 1, 0);
        add(0, 1, 0, 0, 1, 0);
        add(0, 1, 0, 0, 1, 0);
        add(0, 1, 0, 1, 1, 0);
        // Hit wins over flap and tick in FALL
        add(0, 1, 0, 2, 1, 0);
        add(0, 1, 0, 3, 1, 0);
        add(0, 1, 0, 4, 1, 0);
        add(1, 1, 1, 4, 0, 1);
        add(0, 0, 0, 4, 0, 1);
        add(0, 1, 0, 4, 0, 1);
        add(1, 0, 0, 3, 0, 0);
        add(0, 0, 0, 3, 0, 0);
        // Back to FALL at row 4, then flap beats tick in FALL and in RISE
        add(1, 0, 0, 3, 1, 0);
        add(0, 0, 0, 3, 1, 0);
        add(0, 1, 0, 2, 1, 0);
        add(0, 1, 0, 1, 1, 0);
        add(0, 1, 0, 2, 1, 0);
        add(0, 1, 0, 3, 1, 0);
        add(0, 1, 0, 4, 1, 0);
        add(1, 1, 0, 4, 1, 0);
        add(0, 0, 0, 4, 1, 0);
        add(0, 1, 0, 3, 1, 0);
        add(1, 1, 0, 3, 1, 0);
        add(0, 0, 0, 3, 1, 0);
        add(0, 1, 0, 2, 1, 0);
        add(0, 1, 0, 1, 1, 0);
        add(0, 1, 0, 2, 1, 0);
        run_vecs("game");

        // Async reset mid-cycle while rising at row 1
        step(1, 0, 0); check("ar_flap", 3'd2, 1'b1, 1'b0);
        step(0, 1, 0); check("ar_tick", 3'd1, 1'b1, 1'b0);
        flap_key  = 1'b0;
        fall_tick = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("async_reset", 3'd3, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        step(0, 1, 0); check("post_reset_idle", 3'd3, 1'b0, 1'b0);

        // Hit in RISE freezes the row
        step(1, 0, 0); check("rise_enter", 3'd3, 1'b1, 1'b0);
        step(0, 1, 1); check("rise_hit", 3'd3, 1'b0, 1'b1);
        step(0, 1, 0); check("dead_frozen", 3'd3, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
